sprite_motion_ctrl: RTL and testbench

SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

---
 rtl/sprite_motion_ctrl_if.sv | 21 ++
 rtl/sprite_motion_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_motion_ctrl_if.sv
// Bus bundle between the VGA/controller side and sprite_motion_ctrl.
// The master side supplies the frame pulse and buttons; the slave side returns sprite placement.
interface sprite_motion_ctrl_if;
    logic        screenEnd;
    logic [7:0]  buttons;
    logic        sp_en;
    logic [31:0] sp_addr;
    logic [7:0]  sp_x;
    logic [6:0]  sp_y;
    logic        on_ground;

    modport master (
        output screenEnd, buttons,
        input  sp_en, sp_addr, sp_x, sp_y, on_ground
    );

    modport slave (
        input  screenEnd, buttons,
        output sp_en, sp_addr, sp_x, sp_y, on_ground
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion: walk left/right, jump with gravity, two-frame walk animation, start pause.
// Define SPRITE_WRAP_EN to make horizontal motion wrap around the screen instead of saturating.
module sprite_motion_ctrl #(
    parameter int START_X      = 76,
    parameter int START_Y      = 112,
    parameter int FLOOR_Y      = 112,
    parameter int MAX_X        = 152,
    parameter int JUMP_V       = 6,
    parameter int MAX_FALL     = 4,
    parameter int GRAV_PERIOD  = 2,
    parameter int ANIM_PERIOD  = 8,
    parameter int FRAME_STRIDE = 64
) (
    input  logic clk,
    input  logic reset,
    sprite_motion_ctrl_if.slave bus
);
    localparam logic [1:0] ST_GROUND = 2'd0;
    localparam logic [1:0] ST_RISE   = 2'd1;
    localparam logic [1:0] ST_FALL   = 2'd2;

    localparam logic [7:0]        X_START   = 8'(START_X);
    localparam logic [6:0]        Y_START   = 7'(START_Y);
    localparam logic [6:0]        Y_FLOOR   = 7'(FLOOR_Y);
    localparam logic signed [7:0] Y_FLOOR_S = 8'(FLOOR_Y);
    localparam logic signed [4:0] V_JUMP    = 5'(-JUMP_V);
    localparam logic signed [4:0] V_MAX     = 5'(MAX_FALL);
    localparam logic [7:0]        G_LAST    = 8'(GRAV_PERIOD - 1);
    localparam logic [7:0]        A_LAST    = 8'(ANIM_PERIOD - 1);
    localparam logic [31:0]       ADDR_ALT  = 32'(FRAME_STRIDE);
`ifdef SPRITE_WRAP_EN
    localparam logic [7:0]        X_WRAP    = 8'd159;
`else
    localparam logic [7:0]        X_MAX     = 8'(MAX_X);
`endif

    // Only right/left/A/start matter; packed as {start, A, left, right}.
    logic [3:0] btn_sample;
    logic       unused_btn;
    assign btn_sample = {bus.buttons[6], bus.buttons[4], bus.buttons[1], bus.buttons[0]};
    assign unused_btn = ^{bus.buttons[7], bus.buttons[5], bus.buttons[3:2]};

    logic              se_q, tick_q;
    logic [3:0]        btn_q, btn_prev_q;
    logic              en_q, en_d;
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic signed [4:0] vel_q, vel_d;
    logic [1:0]        state_q, state_d;
    logic [7:0]        gcnt_q, gcnt_d;
    logic [7:0]        acnt_q, acnt_d;
    logic              frame_q, frame_d;
    logic [31:0]       addr_q, addr_d;
    logic              ground_q, ground_d;

    logic              frame_tick;
    logic              go_right, go_left, jump_edge, start_edge;
    logic signed [7:0] vel_ext, y_next;
    logic signed [4:0] vel_grav;
    logic [7:0]        gcnt_grav;

    assign frame_tick = bus.screenEnd & ~se_q;
    assign go_right   = btn_q[0] & ~btn_q[1];
    assign go_left    = btn_q[1] & ~btn_q[0];
    assign jump_edge  = btn_q[2] & ~btn_prev_q[2];
    assign start_edge = btn_q[3] & ~btn_prev_q[3];
    assign vel_ext    = {{3{vel_q[4]}}, vel_q};
    assign y_next     = $signed({1'b0, y_q}) + vel_ext;

    // Gravity step: position this tick uses the old velocity, the new one applies next tick.
    always_comb begin
        gcnt_grav = gcnt_q + 8'd1;
        vel_grav  = vel_q;
        if (gcnt_q == G_LAST) begin
            gcnt_grav = '0;
            vel_grav  = (vel_q >= V_MAX) ? V_MAX : vel_q + 5'sd1;
        end
    end

    always_comb begin
        en_d    = en_q;
        x_d     = x_q;
        y_d     = y_q;
        vel_d   = vel_q;
        state_d = state_q;
        gcnt_d  = gcnt_q;
        acnt_d  = acnt_q;
        frame_d = frame_q;
        if (tick_q) begin
            if (start_edge) begin
                en_d = ~en_q;
            end
            if (en_q) begin
`ifdef SPRITE_WRAP_EN
                if (go_right) begin
                    x_d = (x_q >= X_WRAP) ? 8'd0 : x_q + 8'd1;
                end else if (go_left) begin
                    x_d = (x_q == 8'd0) ? X_WRAP : x_q - 8'd1;
                end
`else
                if (go_right) begin
                    x_d = (x_q >= X_MAX) ? X_MAX : x_q + 8'd1;
                end else if (go_left) begin
                    x_d = (x_q == 8'd0) ? 8'd0 : x_q - 8'd1;
                end
`endif
                if (go_right | go_left) begin
                    if (acnt_q == A_LAST) begin
                        acnt_d  = '0;
                        frame_d = ~frame_q;
                    end else begin
                        acnt_d = acnt_q + 8'd1;
                    end
                end else begin
                    acnt_d = '0;
                end

                case (state_q)
                    ST_RISE, ST_FALL: begin
                        gcnt_d = gcnt_grav;
                        vel_d  = vel_grav;
                        if (y_next >= Y_FLOOR_S) begin
                            y_d     = Y_FLOOR;
                            vel_d   = '0;
                            gcnt_d  = '0;
                            state_d = ST_GROUND;
                        end else if (y_next[7]) begin
                            y_d     = '0;
                            vel_d   = '0;
                            gcnt_d  = '0;
                            state_d = ST_FALL;
                        end else begin
                            y_d = y_next[6:0];
                            if (state_q == ST_RISE && !vel_grav[4]) begin
                                state_d = ST_FALL;
                            end
                        end
                    end
                    default: begin
                        if (jump_edge) begin
                            vel_d   = V_JUMP;
                            gcnt_d  = '0;
                            state_d = ST_RISE;
                        end else begin
                            y_d     = Y_FLOOR;
                            vel_d   = '0;
                            state_d = ST_GROUND;
                        end
                    end
                endcase
            end
        end
        addr_d   = frame_d ? ADDR_ALT : 32'd0;
        ground_d = (state_d == ST_GROUND);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            se_q       <= 1'b0;
            tick_q     <= 1'b0;
            btn_q      <= '0;
            btn_prev_q <= '0;
            en_q       <= 1'b1;
            x_q        <= X_START;
            y_q        <= Y_START;
            vel_q      <= '0;
            state_q    <= ST_GROUND;
            gcnt_q     <= '0;
            acnt_q     <= '0;
            frame_q    <= 1'b0;
            addr_q     <= '0;
            ground_q   <= 1'b1;
        end else begin
            se_q   <= bus.screenEnd;
            tick_q <= frame_tick;
            if (frame_tick) begin
                btn_q      <= btn_sample;
                btn_prev_q <= btn_q;
            end
            en_q     <= en_d;
            x_q      <= x_d;
            y_q      <= y_d;
            vel_q    <= vel_d;
            state_q  <= state_d;
            gcnt_q   <= gcnt_d;
            acnt_q   <= acnt_d;
            frame_q  <= frame_d;
            addr_q   <= addr_d;
            ground_q <= ground_d;
        end
    end

    assign bus.sp_en     = en_q;
    assign bus.sp_addr   = addr_q;
    assign bus.sp_x      = x_q;
    assign bus.sp_y      = y_q;
    assign bus.on_ground = ground_q;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: vector table, hand-written corner sequences and a randomized
// run against a frame-level behavioural model of the sprite.
module tb_sprite_motion_ctrl;
    localparam int P_START_X = 76;
    localparam int P_FLOOR   = 112;
    localparam int P_MAX_X   = 152;
    localparam int P_JUMP_V  = 6;
    localparam int P_MAXFALL = 4;
    localparam int P_GRAV    = 2;
    localparam int P_ANIM    = 8;
    localparam int P_STRIDE  = 64;

    logic clk = 1'b0;
    logic reset;
    sprite_motion_ctrl_if bus();

    sprite_motion_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_tick  = 0;

    // Behavioural model state (frame granularity)
    int   m_x, m_y, m_vel, m_g, m_a;
    bit   m_air, m_frame, m_en;
    logic [7:0] m_prev;

    typedef struct {
        logic [7:0] btn;
        int         x;
        int         y;
        bit         gnd;
        int         addr;
    } vec_t;
    vec_t tbl[32];
    int jy[28] = '{106, 100, 95, 90, 86, 82, 79, 76, 74, 72, 71, 70, 70, 70,
                   71, 72, 74, 76, 79, 82, 86, 90, 94, 98, 102, 106, 110, 112};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, n_tick);
        end
    endtask

    task automatic model_reset();
        m_x = P_START_X; m_y = P_FLOOR; m_vel = 0; m_g = 0; m_a = 0;
        m_air = 0; m_frame = 0; m_en = 1; m_prev = '0;
    endtask

    task automatic model_step(input logic [7:0] b);
        bit r, l, a_edge, s_edge, en_now;
        int dx, ny;
        r = b[0]; l = b[1];
        a_edge = b[4] & ~m_prev[4];
        s_edge = b[6] & ~m_prev[6];
        m_prev = b;
        en_now = m_en;
        if (s_edge) m_en = !m_en;
        if (!en_now) return;
        dx = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        if (dx != 0) begin
`ifdef SPRITE_WRAP_EN
            m_x = (m_x + dx + 160) % 160;
`else
            m_x = m_x + dx;
            if (m_x > P_MAX_X) m_x = P_MAX_X;
            if (m_x < 0) m_x = 0;
`endif
            m_a++;
            if (m_a == P_ANIM) begin
                m_a = 0;
                m_frame = !m_frame;
            end
        end else begin
            m_a = 0;
        end
        if (!m_air) begin
            if (a_edge) begin
                m_air = 1; m_vel = -P_JUMP_V; m_g = 0;
            end else begin
                m_y = P_FLOOR; m_vel = 0;
            end
        end else begin
            ny = m_y + m_vel;
            m_g++;
            if (m_g == P_GRAV) begin
                m_g = 0;
                m_vel = (m_vel + 1 > P_MAXFALL) ? P_MAXFALL : m_vel + 1;
            end
            if (ny >= P_FLOOR) begin
                m_y = P_FLOOR; m_vel = 0; m_g = 0; m_air = 0;
            end else if (ny < 0) begin
                m_y = 0; m_vel = 0; m_g = 0;
            end else begin
                m_y = ny;
            end
        end
    endtask

    // One frame: hold buttons, pulse screenEnd for len clocks, let the outputs settle.
    task automatic tick(input logic [7:0] b, input int len);
        @(negedge clk);
        bus.buttons   = b;
        bus.screenEnd = 1'b1;
        repeat (len) @(negedge clk);
        bus.screenEnd = 1'b0;
        repeat (2) @(negedge clk);
        model_step(b);
        n_tick++;
        $display("[TB] tick %0d btn=%02h pulse=%0d -> x=%0d y=%0d gnd=%0b en=%0b addr=%0d",
                 n_tick, b, len, bus.sp_x, bus.sp_y, bus.on_ground, bus.sp_en, bus.sp_addr);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".x"},    32'(bus.sp_x),      32'(m_x));
        check({tag, ".y"},    32'(bus.sp_y),      32'(m_y));
        check({tag, ".gnd"},  32'(bus.on_ground), 32'(!m_air));
        check({tag, ".en"},   32'(bus.sp_en),     32'(m_en));
        check({tag, ".addr"}, bus.sp_addr,        m_frame ? 32'(P_STRIDE) : 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".x"},    32'(bus.sp_x),      32'(P_START_X));
        check({tag, ".y"},    32'(bus.sp_y),      32'(P_FLOOR));
        check({tag, ".gnd"},  32'(bus.on_ground), 32'd1);
        check({tag, ".en"},   32'(bus.sp_en),     32'd1);
        check({tag, ".addr"}, bus.sp_addr,        32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int air_cnt, e;
        logic [7:0] b;

        for (int i = 0; i < 3; i++) tbl[i] = '{8'h01, 77 + i, 112, 1'b1, 0};
        tbl[3] = '{8'h10, 79, 112, 1'b0, 0};
        for (int i = 0; i < 28; i++) tbl[4 + i] = '{8'h00, 79, jy[i], (i == 27), 0};

        reset = 1'b0; bus.screenEnd = 1'b0; bus.buttons = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check_reset_state("reset");

        // Walk three frames, then a full jump arc
        for (int i = 0; i < 32; i++) begin
            tick(tbl[i].btn, 4);
            check($sformatf("tbl%0d.x", i),    32'(bus.sp_x),      32'(tbl[i].x));
            check($sformatf("tbl%0d.y", i),    32'(bus.sp_y),      32'(tbl[i].y));
            check($sformatf("tbl%0d.gnd", i),  32'(bus.on_ground), 32'(tbl[i].gnd));
            check($sformatf("tbl%0d.addr", i), bus.sp_addr,        32'(tbl[i].addr));
        end

        // Animation: frame flips on the 8th moving tick, holds when idle
        for (int k = 1; k <= 8; k++) begin
            tick(8'h01, 4);
            check("anim1.addr", bus.sp_addr, (k == 8) ? 32'd64 : 32'd0);
        end
        for (int k = 1; k <= 3; k++) begin
            tick(8'h00, 4);
            check("anim_hold.addr", bus.sp_addr, 32'd64);
        end
        for (int k = 1; k <= 8; k++) begin
            tick(8'h01, 4);
            check("anim2.addr", bus.sp_addr, (k == 8) ? 32'd0 : 32'd64);
        end

        // A held for 40 frames jumps exactly once
        air_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            tick(8'h10, 4);
            if (!bus.on_ground) air_cnt++;
            check_model("a_held");
        end
        check("a_held.air_frames", 32'(air_cnt), 32'd28);
        check("a_held.gnd", 32'(bus.on_ground), 32'd1);
        tick(8'h00, 4);

        // Right edge, then left edge
        for (int k = 1; k <= 70; k++) begin
            tick(8'h01, 4);
            check_model("run_right");
        end
`ifndef SPRITE_WRAP_EN
        for (int k = 0; k < 2; k++) begin
            tick(8'h01, 4);
            check("sat_right.x", 32'(bus.sp_x), 32'(P_MAX_X));
        end
`endif
        for (int k = 1; k <= 160; k++) begin
            tick(8'h02, 4);
            check_model("run_left");
        end
`ifndef SPRITE_WRAP_EN
        tick(8'h02, 4);
        check("sat_left.x", 32'(bus.sp_x), 32'd0);
`endif

        // A long screenEnd pulse still moves exactly one step
        e = m_x + 1;
        tick(8'h01, 10);
        check("long_pulse.x", 32'(bus.sp_x), 32'(e));

        // Start pauses and resumes
        tick(8'h40, 4);
        check("pause.en", 32'(bus.sp_en), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick(8'h01, 4);
            check("pause.x", 32'(bus.sp_x), 32'(e));
            check("pause.en_hold", 32'(bus.sp_en), 32'd0);
        end
        tick(8'h40, 4);
        check("resume.en", 32'(bus.sp_en), 32'd1);
        check("resume.x", 32'(bus.sp_x), 32'(e));
        tick(8'h01, 4);
        check("resume_move.x", 32'(bus.sp_x), 32'(e + 1));

        // Reset in mid-air leaves no residual velocity
        tick(8'h10, 4);
        for (int k = 0; k < 3; k++) tick(8'h00, 4);
        check("midjump.gnd", 32'(bus.on_ground), 32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        model_reset();
        check_reset_state("midjump_reset");
        tick(8'h00, 4);
        check("after_reset.y", 32'(bus.sp_y), 32'(P_FLOOR));
        check("after_reset.gnd", 32'(bus.on_ground), 32'd1);

        // A frame pulse entirely inside reset does nothing
        @(negedge clk);
        reset = 1'b0; bus.buttons = 8'h01; bus.screenEnd = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1; bus.screenEnd = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        check("tick_in_reset.x", 32'(bus.sp_x), 32'(P_START_X));

        // Randomized frames against the model
        for (int k = 0; k < 300; k++) begin
            b = 8'($urandom) & 8'hBF;
            if ($urandom_range(0, 15) == 0) b[6] = 1'b1;
            tick(b, $urandom_range(1, 6));
            check_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
